// File: rtl/move_sequencer.sv
// Map move sequencer: one move per vs edge, read-modify-write of the map through a single-port RAM, 1..8 cycles uncontested.
// Render reads always win the port (data returns next cycle); RD/WR states hold while rnd_req is high, WT states never stall.
module move_sequencer #(
  parameter int COLS = 16,
  parameter int ROWS = 12,
  parameter int P_X0 = 6,
  parameter int P_Y0 = 3,
  parameter int E_X  = 10,
  parameter int E_Y  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vs,
  input  logic [3:0] dirMove,
  input  logic       rnd_req,
  input  logic [7:0] rnd_addr,
  output logic [2:0] rnd_data,
  output logic       rnd_valid,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [2:0] mem_wdata,
  input  logic [2:0] mem_rdata,
  output logic [3:0] px,
  output logic [3:0] py,
  output logic       busy,
  output logic [9:0] moves,
  output logic [1:0] gameState
);
  localparam logic [2:0] C_EMPTY  = 3'b000;
  localparam logic [2:0] C_WALL   = 3'b001;
  localparam logic [2:0] C_BOX    = 3'b010;
  localparam logic [2:0] C_TERM   = 3'b011;
  localparam logic [2:0] C_PERSON = 3'b100;

  typedef enum logic [3:0] {IDLE, RD_N, WT_N, RD_F, WT_F, WR_F, WR_N, WR_P, DONE} state_t;
  state_t state;

  logic              vs_r, vs_d, edge_det;
  logic [3:0]        dir, dsel;
  logic              win_pend, dir_onehot, stall;
  logic signed [4:0] dx, dy, nx, ny, fx, fy;
  logic              n_oob, f_oob, at_end, f_is_end;
  logic [7:0]        n_addr, f_addr, p_addr;

  assign edge_det   = vs_r & ~vs_d;
  assign dir_onehot = (dirMove == 4'b0001) || (dirMove == 4'b0010) ||
                      (dirMove == 4'b0100) || (dirMove == 4'b1000);
  // In IDLE the incoming request decides the out-of-bounds shortcut.
  assign dsel = (state == IDLE) ? dirMove : dir;

  always_comb begin
    dx = 5'sd0;
    dy = 5'sd0;
    case (dsel)
      4'b0001: dy = -5'sd1;
      4'b0010: dy = 5'sd1;
      4'b0100: dx = -5'sd1;
      4'b1000: dx = 5'sd1;
      default: ;
    endcase
  end

  assign nx = $signed({1'b0, px}) + dx;
  assign ny = $signed({1'b0, py}) + dy;
  assign fx = nx + dx;
  assign fy = ny + dy;

  assign n_oob = nx[4] || ny[4] || (int'(nx) >= COLS) || (int'(ny) >= ROWS);
  assign f_oob = fx[4] || fy[4] || (int'(fx) >= COLS) || (int'(fy) >= ROWS);

  assign n_addr   = {ny[3:0], nx[3:0]};
  assign f_addr   = {fy[3:0], fx[3:0]};
  assign p_addr   = {py, px};
  assign at_end   = (px == 4'(E_X)) && (py == 4'(E_Y));
  assign f_is_end = (fx[3:0] == 4'(E_X)) && (fy[3:0] == 4'(E_Y));

  assign stall    = rnd_req && (state inside {RD_N, RD_F, WR_F, WR_N, WR_P});
  assign busy     = (state != IDLE);
  assign rnd_data = mem_rdata;

  always_comb begin
    mem_addr  = rnd_addr;
    mem_we    = 1'b0;
    mem_wdata = C_EMPTY;
    if (!rnd_req) begin
      case (state)
        RD_N: mem_addr = n_addr;
        RD_F: mem_addr = f_addr;
        WR_F: begin mem_addr = f_addr; mem_we = 1'b1; mem_wdata = C_BOX;    end
        WR_N: begin mem_addr = n_addr; mem_we = 1'b1; mem_wdata = C_PERSON; end
        WR_P: begin
          mem_addr  = p_addr;
          mem_we    = 1'b1;
          mem_wdata = at_end ? C_TERM : C_EMPTY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      vs_r      <= 1'b0;
      vs_d      <= 1'b0;
      dir       <= 4'b0000;
      win_pend  <= 1'b0;
      px        <= 4'(P_X0);
      py        <= 4'(P_Y0);
      moves     <= 10'd0;
      gameState <= 2'b00;
      rnd_valid <= 1'b0;
    end else begin
      vs_r      <= vs;
      vs_d      <= vs_r;
      rnd_valid <= rnd_req;

      if (edge_det) begin
        if (gameState == 2'b00)      gameState <= 2'b01;
        else if (gameState == 2'b01) gameState <= 2'b10;
      end

      case (state)
        IDLE: if (edge_det && (gameState == 2'b01 || gameState == 2'b10) && dir_onehot) begin
          dir      <= dirMove;
          win_pend <= 1'b0;
          state    <= n_oob ? DONE : RD_N;
        end
        RD_N: if (!stall) state <= WT_N;
        WT_N: begin
          case (mem_rdata)
            C_EMPTY, C_TERM: state <= WR_N;
            C_BOX:           state <= f_oob ? DONE : RD_F;
            C_WALL:          state <= DONE;
            default:         state <= DONE;
          endcase
        end
        RD_F: if (!stall) state <= WT_F;
        WT_F: state <= (mem_rdata == C_EMPTY || mem_rdata == C_TERM) ? WR_F : DONE;
        WR_F: if (!stall) begin
          state    <= WR_N;
          win_pend <= f_is_end;
        end
        WR_N: if (!stall) state <= WR_P;
        WR_P: if (!stall) begin
          state <= DONE;
          px    <= nx[3:0];
          py    <= ny[3:0];
          if (moves != 10'd1023) moves <= moves + 10'd1;
          if (win_pend) gameState <= 2'b11;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: behavioural 1-cycle-latency RAM with a write log, one task per scenario.
`timescale 1ns/1ps
module tb_move_sequencer;
  logic       clk = 1'b0;
  logic       reset, vs, rnd_req, rnd_valid, mem_we, busy;
  logic [3:0] dirMove, px, py;
  logic [7:0] rnd_addr, mem_addr;
  logic [2:0] rnd_data, mem_wdata, mem_rdata;
  logic [9:0] moves;
  logic [1:0] gameState;

  int total = 0;
  int bad   = 0;

  logic [2:0] ram [256];
  logic [7:0] wlog_a [$];
  logic [2:0] wlog_d [$];

  always #5 clk = ~clk;

  move_sequencer dut (
    .clk(clk), .reset(reset), .vs(vs), .dirMove(dirMove),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .px(px), .py(py), .busy(busy), .moves(moves), .gameState(gameState)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
    end
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_map();
    for (int i = 0; i < 256; i++) ram[i] = 3'b000;
  endtask

  task automatic clear_log();
    wlog_a.delete();
    wlog_d.delete();
  endtask

  task automatic pulse_vs();
    @(negedge clk) vs = 1'b1;
    @(negedge clk) vs = 1'b0;
  endtask

  // One field with the given request; counts busy cycles over a fixed window.
  task automatic run_move(input logic [3:0] d, output int nbusy);
    dirMove = d;
    pulse_vs();
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    dirMove = 4'b0000;
  endtask

  task automatic walk(input logic [3:0] d, input int n);
    int nb;
    for (int i = 0; i < n; i++) run_move(d, nb);
  endtask

  task automatic test_reset();
    int nb;
    reset = 1'b0; vs = 1'b0; dirMove = 4'b0000; rnd_req = 1'b0; rnd_addr = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (px !== 4'd6) begin bad++; $display("FAIL reset_px: got %0d want 6", px); end
    total++; if (py !== 4'd3) begin bad++; $display("FAIL reset_py: got %0d want 3", py); end
    total++; if (moves !== 10'd0) begin bad++; $display("FAIL reset_moves: got %0d want 0", moves); end
    total++; if (gameState !== 2'b00) begin bad++; $display("FAIL reset_state: got %0b want 00", gameState); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b want 0", mem_we); end
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %0b want 0", rnd_valid); end
    @(negedge clk) reset = 1'b1;
    run_move(4'b0001, nb);
    total++; if (gameState !== 2'b01) begin bad++; $display("FAIL first_edge_state: got %0b want 01", gameState); end
    total++; if (nb !== 0) begin bad++; $display("FAIL first_edge_busy: got %0d want 0", nb); end
    total++; if (py !== 4'd3) begin bad++; $display("FAIL first_edge_py: got %0d want 3", py); end
  endtask

  task automatic test_free_move();
    int nb;
    clear_map();
    ram[8'h36] = 3'b100;
    clear_log();
    run_move(4'b0010, nb);
    total++; if (nb !== 5) begin bad++; $display("FAIL free_busy: got %0d want 5", nb); end
    total++; if (wlog_a.size() !== 2) begin bad++; $display("FAIL free_nwrites: got %0d want 2", wlog_a.size()); end
    else begin
      total++; if (wlog_a[0] !== 8'h46 || wlog_d[0] !== 3'b100) begin bad++; $display("FAIL free_w0: got %h<=%b want 46<=100", wlog_a[0], wlog_d[0]); end
      total++; if (wlog_a[1] !== 8'h36 || wlog_d[1] !== 3'b000) begin bad++; $display("FAIL free_w1: got %h<=%b want 36<=000", wlog_a[1], wlog_d[1]); end
    end
    total++; if (px !== 4'd6 || py !== 4'd4) begin bad++; $display("FAIL free_pos: got (%0d,%0d) want (6,4)", px, py); end
    total++; if (moves !== 10'd1) begin bad++; $display("FAIL free_moves: got %0d want 1", moves); end
    total++; if (gameState !== 2'b10) begin bad++; $display("FAIL free_state: got %0b want 10", gameState); end
  endtask

  task automatic test_ignored();
    int nb;
    clear_log();
    run_move(4'b0011, nb);
    total++; if (nb !== 0) begin bad++; $display("FAIL ignore_busy: got %0d want 0", nb); end
    total++; if (wlog_a.size() !== 0) begin bad++; $display("FAIL ignore_writes: got %0d want 0", wlog_a.size()); end
    total++; if (py !== 4'd4) begin bad++; $display("FAIL ignore_py: got %0d want 4", py); end
  endtask

  task automatic test_blocked();
    int nb;
    ram[8'h47] = 3'b001;
    clear_log();
    run_move(4'b1000, nb);
    total++; if (nb !== 3) begin bad++; $display("FAIL wall_busy: got %0d want 3", nb); end
    total++; if (wlog_a.size() !== 0) begin bad++; $display("FAIL wall_writes: got %0d want 0", wlog_a.size()); end
    total++; if (px !== 4'd6) begin bad++; $display("FAIL wall_px: got %0d want 6", px); end
    ram[8'h56] = 3'b010;
    ram[8'h66] = 3'b001;
    run_move(4'b0010, nb);
    total++; if (nb !== 5) begin bad++; $display("FAIL boxwall_busy: got %0d want 5", nb); end
    total++; if (wlog_a.size() !== 0) begin bad++; $display("FAIL boxwall_writes: got %0d want 0", wlog_a.size()); end
    total++; if (py !== 4'd4) begin bad++; $display("FAIL boxwall_py: got %0d want 4", py); end
    total++; if (moves !== 10'd1) begin bad++; $display("FAIL blocked_moves: got %0d want 1", moves); end
  endtask

  task automatic test_boundary();
    int nb;
    clear_map();
    walk(4'b0001, 1);
    walk(4'b0100, 6);
    total++; if (px !== 4'd0 || py !== 4'd3) begin bad++; $display("FAIL walk_left_pos: got (%0d,%0d) want (0,3)", px, py); end
    clear_log();
    run_move(4'b0100, nb);
    total++; if (nb !== 1) begin bad++; $display("FAIL oob_busy: got %0d want 1", nb); end
    total++; if (wlog_a.size() !== 0) begin bad++; $display("FAIL oob_writes: got %0d want 0", wlog_a.size()); end
    total++; if (px !== 4'd0) begin bad++; $display("FAIL oob_px: got %0d want 0", px); end
    total++; if (moves !== 10'd8) begin bad++; $display("FAIL oob_moves: got %0d want 8", moves); end
  endtask

  task automatic test_contention();
    int nb;
    logic exp_v;
    ram[8'h77] = 3'b001;
    clear_log();
    dirMove = 4'b1000;
    pulse_vs();
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) nb++;
      exp_v = (k >= 1 && k <= 4);
      total++; if (rnd_valid !== exp_v) begin bad++; $display("FAIL rvalid_k%0d: got %0b want %0b", k, rnd_valid, exp_v); end
      if (exp_v) begin
        total++; if (rnd_data !== 3'b001) begin bad++; $display("FAIL rdata_k%0d: got %b want 001", k, rnd_data); end
      end
      rnd_req  = (k < 4);
      rnd_addr = 8'h77;
    end
    rnd_req = 1'b0;
    dirMove = 4'b0000;
    total++; if (nb !== 9) begin bad++; $display("FAIL stall_busy: got %0d want 9", nb); end
    total++; if (wlog_a.size() !== 2) begin bad++; $display("FAIL stall_nwrites: got %0d want 2", wlog_a.size()); end
    else begin
      total++; if (wlog_a[0] !== 8'h31 || wlog_d[0] !== 3'b100) begin bad++; $display("FAIL stall_w0: got %h<=%b want 31<=100", wlog_a[0], wlog_d[0]); end
      total++; if (wlog_a[1] !== 8'h30 || wlog_d[1] !== 3'b000) begin bad++; $display("FAIL stall_w1: got %h<=%b want 30<=000", wlog_a[1], wlog_d[1]); end
    end
    total++; if (px !== 4'd1) begin bad++; $display("FAIL stall_px: got %0d want 1", px); end
    total++; if (moves !== 10'd9) begin bad++; $display("FAIL stall_moves: got %0d want 9", moves); end
  endtask

  task automatic test_push_win();
    int nb;
    walk(4'b1000, 7);
    walk(4'b0010, 2);
    total++; if (px !== 4'd8 || py !== 4'd5) begin bad++; $display("FAIL walk_push_pos: got (%0d,%0d) want (8,5)", px, py); end
    ram[8'h59] = 3'b010;
    ram[8'h5A] = 3'b011;
    clear_log();
    run_move(4'b1000, nb);
    total++; if (nb !== 8) begin bad++; $display("FAIL push_busy: got %0d want 8", nb); end
    total++; if (wlog_a.size() !== 3) begin bad++; $display("FAIL push_nwrites: got %0d want 3", wlog_a.size()); end
    else begin
      total++; if (wlog_a[0] !== 8'h5A || wlog_d[0] !== 3'b010) begin bad++; $display("FAIL push_w0: got %h<=%b want 5a<=010", wlog_a[0], wlog_d[0]); end
      total++; if (wlog_a[1] !== 8'h59 || wlog_d[1] !== 3'b100) begin bad++; $display("FAIL push_w1: got %h<=%b want 59<=100", wlog_a[1], wlog_d[1]); end
      total++; if (wlog_a[2] !== 8'h58 || wlog_d[2] !== 3'b000) begin bad++; $display("FAIL push_w2: got %h<=%b want 58<=000", wlog_a[2], wlog_d[2]); end
    end
    total++; if (gameState !== 2'b11) begin bad++; $display("FAIL win_state: got %0b want 11", gameState); end
    total++; if (px !== 4'd9 || py !== 4'd5) begin bad++; $display("FAIL push_pos: got (%0d,%0d) want (9,5)", px, py); end
    total++; if (moves !== 10'd19) begin bad++; $display("FAIL push_moves: got %0d want 19", moves); end
    run_move(4'b0100, nb);
    total++; if (nb !== 0) begin bad++; $display("FAIL won_busy: got %0d want 0", nb); end
    total++; if (gameState !== 2'b11) begin bad++; $display("FAIL won_hold: got %0b want 11", gameState); end
  endtask

  task automatic test_reset_mid();
    int nb;
    bit found;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    clear_map();
    ram[8'h36] = 3'b100;
    run_move(4'b0000, nb);
    clear_log();
    dirMove = 4'b0010;
    pulse_vs();
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_we) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL wait_wr_n: got %0b want 1", found); end
    total++; if (mem_addr !== 8'h46) begin bad++; $display("FAIL wr_n_addr: got %h want 46", mem_addr); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL abort_we: got %0b want 0", mem_we); end
    total++; if (px !== 4'd6 || py !== 4'd3) begin bad++; $display("FAIL abort_pos: got (%0d,%0d) want (6,3)", px, py); end
    total++; if (gameState !== 2'b00) begin bad++; $display("FAIL abort_state: got %0b want 00", gameState); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", busy); end
    reset = 1'b1;
    dirMove = 4'b0000;
    repeat (5) @(negedge clk);
    total++; if (wlog_a.size() !== 1) begin bad++; $display("FAIL abort_nwrites: got %0d want 1", wlog_a.size()); end
    run_move(4'b0000, nb);
    total++; if (gameState !== 2'b01) begin bad++; $display("FAIL rearm_state: got %0b want 01", gameState); end
  endtask

  initial begin
    clear_map();
    test_reset();
    test_free_move();
    test_ignored();
    test_blocked();
    test_boundary();
    test_contention();
    test_push_win();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
